controller_sequencer: RTL and testbench

Six-state ring-counter controller for the SAP-1 datapath. It generates the per-cycle control word that drives the program counter (increment and bus-enable), MAR, RAM, instruction register, accumulator, ALU, B register and output register. It fetches and executes LDA/ADD/SUB/OUT/HLT from the opcode nibble supplied by the instruction register. It is the initiator for every load/enable strobe that the datapath registers respond to.

---
 rtl/controller_sequencer.sv | 150 +++++++++++++++
 tb/tb_controller_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : controller_sequencer
//  Description : Six-state ring-counter controller for the SAP-1 datapath.
//                Generates the per-state control word for fetch and for the
//                LDA / ADD / SUB / OUT / HLT execute phases.
//  Revision    : 1.0  initial release
// ============================================================================
module controller_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   output logic [5:0] t_state,
   output logic       pc_incr,
   output logic       pc_enable,
   output logic       mar_load,
   output logic       ram_enable,
   output logic       ir_load,
   output logic       ir_enable,
   output logic       a_load,
   output logic       a_enable,
   output logic       alu_sub,
   output logic       alu_enable,
   output logic       b_load,
   output logic       out_load,
   output logic       halt
);

   // One-hot ring states
   localparam logic [5:0] c_T1 = 6'b000001;
   localparam logic [5:0] c_T2 = 6'b000010;
   localparam logic [5:0] c_T3 = 6'b000100;
   localparam logic [5:0] c_T4 = 6'b001000;
   localparam logic [5:0] c_T5 = 6'b010000;
   localparam logic [5:0] c_T6 = 6'b100000;

   // Opcode nibbles
   localparam logic [3:0] c_OP_LDA = 4'b0000;
   localparam logic [3:0] c_OP_ADD = 4'b0001;
   localparam logic [3:0] c_OP_SUB = 4'b0010;
   localparam logic [3:0] c_OP_OUT = 4'b1110;
   localparam logic [3:0] c_OP_HLT = 4'b1111;

   logic [5:0] r_t_state;
   logic       r_halt;
   logic       w_one_hot;
   logic       w_active;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign w_one_hot = (r_t_state != 6'd0) &&
                      ((r_t_state & (r_t_state - 6'd1)) == 6'd0);

   // Strobes are only live while running; reset and halt both silence them.
   assign w_active = !reset && !r_halt;

   assign t_state = r_t_state;
   assign halt    = r_halt;

   // Ring advance, halt capture at the end of T4, illegal-state recovery.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_t_state <= c_T1;
         r_halt    <= 1'b0;
      end else if (r_halt) begin
         // Parked at T4 until reset; also repairs any upset while halted.
         r_t_state <= c_T4;
      end else if (!w_one_hot) begin
         r_t_state <= c_T1;
      end else if ((r_t_state == c_T4) && (opcode == c_OP_HLT)) begin
         r_halt    <= 1'b1;
      end else begin
         r_t_state <= {r_t_state[4:0], r_t_state[5]};
      end
   end

   // Control word decode from ring state and opcode; equality compares mean
   // an illegal ring value decodes to no strobes at all.
   always_comb begin
      pc_incr    = 1'b0;
      pc_enable  = 1'b0;
      mar_load   = 1'b0;
      ram_enable = 1'b0;
      ir_load    = 1'b0;
      ir_enable  = 1'b0;
      a_load     = 1'b0;
      a_enable   = 1'b0;
      alu_sub    = 1'b0;
      alu_enable = 1'b0;
      b_load     = 1'b0;
      out_load   = 1'b0;
      if (w_active) begin
         case (r_t_state)
            c_T1: begin
               pc_enable = 1'b1;
               mar_load  = 1'b1;
            end
            c_T2: begin
               pc_incr = 1'b1;
            end
            c_T3: begin
               ram_enable = 1'b1;
               ir_load    = 1'b1;
            end
            c_T4: begin
               case (opcode)
                  c_OP_LDA, c_OP_ADD, c_OP_SUB: begin
                     ir_enable = 1'b1;
                     mar_load  = 1'b1;
                  end
                  c_OP_OUT: begin
                     a_enable = 1'b1;
                     out_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            c_T5: begin
               case (opcode)
                  c_OP_LDA: begin
                     ram_enable = 1'b1;
                     a_load     = 1'b1;
                  end
                  c_OP_ADD, c_OP_SUB: begin
                     ram_enable = 1'b1;
                     b_load     = 1'b1;
                  end
                  default: ;
               endcase
            end
            c_T6: begin
               case (opcode)
                  c_OP_ADD: begin
                     alu_enable = 1'b1;
                     a_load     = 1'b1;
                  end
                  c_OP_SUB: begin
                     alu_enable = 1'b1;
                     a_load     = 1'b1;
                     alu_sub    = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_controller_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controller_sequencer
//  Description : Self-checking bench for controller_sequencer. A step/halt
//                model predicts the control word every cycle; directed
//                literal checks pin fetch, execute, halt and reset behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_controller_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] opcode = 4'b0000;
   logic [5:0] t_state;
   logic pc_incr, pc_enable, mar_load, ram_enable, ir_load, ir_enable;
   logic a_load, a_enable, alu_sub, alu_enable, b_load, out_load, halt;

   // Control word bit positions used by the model and the literals below
   localparam int B_PC_INCR = 11, B_PC_EN = 10, B_MAR = 9, B_RAM_EN = 8;
   localparam int B_IR_LD = 7, B_IR_EN = 6, B_A_LD = 5, B_A_EN = 4;
   localparam int B_SUB = 3, B_ALU_EN = 2, B_B_LD = 1, B_OUT_LD = 0;

   int checks = 0;
   int errors = 0;

   // Model state: instruction step 1..6 and halted flag
   int m_step = 1;
   bit m_halt = 1'b0;

   logic [11:0] dut_word;
   assign dut_word = {pc_incr, pc_enable, mar_load, ram_enable, ir_load, ir_enable,
                      a_load, a_enable, alu_sub, alu_enable, b_load, out_load};

   controller_sequencer dut (
      .clk(clk), .reset(reset), .opcode(opcode), .t_state(t_state),
      .pc_incr(pc_incr), .pc_enable(pc_enable), .mar_load(mar_load),
      .ram_enable(ram_enable), .ir_load(ir_load), .ir_enable(ir_enable),
      .a_load(a_load), .a_enable(a_enable), .alu_sub(alu_sub),
      .alu_enable(alu_enable), .b_load(b_load), .out_load(out_load),
      .halt(halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Microcode table expressed per instruction step and mnemonic
   function automatic logic [11:0] model_word(input int step, input bit hlt,
                                              input bit rst, input logic [3:0] op);
      logic [11:0] w;
      bit mem_op;
      w = '0;
      mem_op = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
      if (!rst && !hlt) begin
         case (step)
            1: begin w[B_PC_EN] = 1'b1; w[B_MAR] = 1'b1; end
            2: w[B_PC_INCR] = 1'b1;
            3: begin w[B_RAM_EN] = 1'b1; w[B_IR_LD] = 1'b1; end
            4: if (mem_op) begin
                  w[B_IR_EN] = 1'b1; w[B_MAR] = 1'b1;
               end else if (op == 4'hE) begin
                  w[B_A_EN] = 1'b1; w[B_OUT_LD] = 1'b1;
               end
            5: if (op == 4'h0) begin
                  w[B_RAM_EN] = 1'b1; w[B_A_LD] = 1'b1;
               end else if (mem_op) begin
                  w[B_RAM_EN] = 1'b1; w[B_B_LD] = 1'b1;
               end
            6: if (op == 4'h1 || op == 4'h2) begin
                  w[B_ALU_EN] = 1'b1; w[B_A_LD] = 1'b1; w[B_SUB] = (op == 4'h2);
               end
            default: ;
         endcase
      end
      return w;
   endfunction

   // Model advance: reset restarts at step 1, HLT parks at step 4
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_step = 1;
         m_halt = 1'b0;
      end else if (!m_halt) begin
         if (m_step == 4 && opcode == 4'hF) m_halt = 1'b1;
         else m_step = (m_step == 6) ? 1 : m_step + 1;
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle
   always @(negedge clk) begin
      logic [5:0] exp_t;
      exp_t = 6'(1 << (m_step - 1));
      check("t_state", {6'd0, t_state}, {6'd0, exp_t});
      check("halt", {11'd0, halt}, {11'd0, m_halt});
      check("ctrl_word", dut_word, model_word(m_step, m_halt, reset, opcode));
      check("bus_excl",
            {11'd0, ($countones({pc_enable, ram_enable, ir_enable, a_enable, alu_enable}) <= 1)},
            12'd1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Move to one time unit after the edge that starts T1 (bounded)
   task automatic sync_t1();
      int guard;
      guard = 0;
      while (m_step != 1 && guard < 12) begin
         tick(1);
         guard++;
      end
      if (m_step != 1) begin
         errors++;
         $display("FAIL sync_t1 actual=%0d required=1", m_step);
      end
   endtask

   task automatic run_lit(input string name, input logic [3:0] op,
                          input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6);
      sync_t1();
      opcode = op;
      tick(3);
      check({name, "_T4"}, dut_word, w4);
      tick(1);
      check({name, "_T5"}, dut_word, w5);
      tick(1);
      check({name, "_T6"}, dut_word, w6);
      tick(1);
      check({name, "_wrap"}, {6'd0, t_state}, 12'h001);
   endtask

   logic [5:0] seq [7] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                           6'b010000, 6'b100000, 6'b000001};

   initial begin
      int pulses;
      #1 reset = 1'b1;
      tick(2);
      check("reset_word", dut_word, 12'h000);
      check("reset_t", {6'd0, t_state}, 12'h001);
      reset = 1'b0;

      // Fetch sequence after release
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("fetch_seq", {6'd0, t_state}, {6'd0, seq[i]});
         if (i == 0) check("fetch_T1", dut_word, 12'h600);
         if (i == 1) check("fetch_T2", dut_word, 12'h800);
         if (i == 2) check("fetch_T3", dut_word, 12'h180);
      end

      run_lit("LDA", 4'h0, 12'h240, 12'h120, 12'h000);
      run_lit("ADD", 4'h1, 12'h240, 12'h102, 12'h024);
      run_lit("SUB", 4'h2, 12'h240, 12'h102, 12'h02C);
      run_lit("OUT", 4'hE, 12'h011, 12'h000, 12'h000);
      run_lit("NOP", 4'h5, 12'h000, 12'h000, 12'h000);

      // Randomized program, excluding HLT
      for (int k = 0; k < 50; k++) begin
         sync_t1();
         opcode = 4'($urandom_range(0, 14));
         tick(1);
      end

      // Reset during T5 of an ADD
      sync_t1();
      opcode = 4'h1;
      tick(4);
      check("add_T5_bload", {11'd0, b_load}, 12'd1);
      #2 reset = 1'b1;
      #1;
      check("midreset_t", {6'd0, t_state}, 12'h001);
      check("midreset_bload", {11'd0, b_load}, 12'd0);
      tick(1);
      reset = 1'b0;

      // HLT: halt rises on the edge ending T4 and the ring stays parked
      sync_t1();
      opcode = 4'hF;
      tick(3);
      check("hlt_T4_pre", {11'd0, halt}, 12'd0);
      check("hlt_T4_word", dut_word, 12'h000);
      tick(1);
      check("hlt_set", {11'd0, halt}, 12'd1);
      check("hlt_t", {6'd0, t_state}, 12'h008);
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (pc_incr) pulses++;
      end
      check("hlt_pcincr", 12'(pulses), 12'd0);
      check("hlt_stuck", {6'd0, t_state}, 12'h008);

      // Asynchronous reset while halted
      #2 reset = 1'b1;
      #1;
      check("hltreset_halt", {11'd0, halt}, 12'd0);
      check("hltreset_t", {6'd0, t_state}, 12'h001);
      check("hltreset_word", dut_word, 12'h000);
      tick(1);
      reset = 1'b0;
      opcode = 4'h0;
      tick(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
